// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared neural-network datapath types and helpers
package nn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Counter width for addressing n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_output_sequencer.sv
// rtl/layer_output_sequencer.sv - serialises one layer's parallel neuron outputs into a valid/ready stream
module layer_output_sequencer
    import nn_pkg::*;
#(
    parameter int NEURONS_NUM = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NEURONS_NUM-1:0]            i_data_in_valid,
    input  logic [NEURONS_NUM*DATA_WIDTH-1:0] i_data_in,
    input  logic                              i_ready,
    output logic                              o_data_out_valid,
    output logic [DATA_WIDTH-1:0]             o_data_out,
    output logic                              o_last,
    output logic                              o_busy,
    output logic                              o_overrun,
    output logic                              o_partial
);

    localparam int                IDX_W    = idx_width(NEURONS_NUM);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NEURONS_NUM - 1);

    state_t                            r_state;
    state_t                            w_state_next;
    logic [NEURONS_NUM*DATA_WIDTH-1:0] r_buf;
    logic [NEURONS_NUM*DATA_WIDTH-1:0] w_buf_next;
    logic [IDX_W-1:0]                  r_index;
    logic [IDX_W-1:0]                  w_index_next;
    logic                              r_overrun;
    logic                              w_overrun_next;
    logic                              r_partial;
    logic                              w_partial_next;

    logic                              w_trigger;
    logic                              w_all_valid;
    logic                              w_sending;
    logic                              w_at_last;
    logic                              w_handshake;

    assign w_trigger   = |i_data_in_valid;
    assign w_all_valid = &i_data_in_valid;
    assign w_sending   = (r_state == SEND);
    assign w_at_last   = w_sending && (r_index == LAST_IDX);
    // Valid comes purely from state, so ready never feeds back into valid.
    assign w_handshake = w_sending && i_ready;

    // State, shift buffer, index and sticky flags; async reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_buf     <= '0;
            r_index   <= '0;
            r_overrun <= 1'b0;
            r_partial <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_buf     <= w_buf_next;
            r_index   <= w_index_next;
            r_overrun <= w_overrun_next;
            r_partial <= w_partial_next;
        end
    end

    // Next-state logic: capture when idle or on the final beat, shift on each handshake, otherwise flag drops.
    always_comb begin
        w_state_next   = r_state;
        w_buf_next     = r_buf;
        w_index_next   = r_index;
        w_overrun_next = r_overrun;
        w_partial_next = r_partial;

        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_buf_next     = i_data_in;
                    w_index_next   = '0;
                    w_state_next   = SEND;
                    w_partial_next = r_partial | ~w_all_valid;
                end
            end
            SEND: begin
                if (w_handshake) begin
                    w_buf_next = r_buf >> DATA_WIDTH;
                    if (w_at_last) begin
                        // Park the index at 0 so it never passes the last neuron.
                        w_index_next = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_index_next = r_index + 1'b1;
                    end
                end
                if (w_trigger) begin
                    if (w_handshake && w_at_last) begin
                        // Back-to-back vector: the slot frees this very cycle, so no bubble.
                        w_buf_next     = i_data_in;
                        w_index_next   = '0;
                        w_state_next   = SEND;
                        w_partial_next = r_partial | ~w_all_valid;
                    end else begin
                        w_overrun_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_data_out_valid = w_sending;
    assign o_busy           = w_sending;
    assign o_data_out       = r_buf[DATA_WIDTH-1:0];
    assign o_last           = w_at_last;
    assign o_overrun        = r_overrun;
    assign o_partial        = r_partial;

endmodule
